// File: rtl/mem_lsu.sv
// Load/store unit on the data-RAM initiator port: word-aligned RAM accesses,
// byte-lane masks and shifted store data, load extraction/extension, error flagging.
module mem_lsu #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [31:0]       ram_data_o,
    output logic [3:0]        ram_wr_mask_o,
    input  logic [31:0]       ram_data_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e     state_q;
    logic [2:0] funct3_q;
    logic       we_q;
    logic [1:0] lsb_q;
    logic [1:0] cnt_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_err;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        req_illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                      (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
        req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                         ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_err = req_illegal || req_misaligned;
    end

    always_comb begin
        st_mask = 4'b1111;
        st_data = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00: begin
                st_mask = 4'b0001 << req_addr_i[1:0];
                st_data = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << {req_addr_i[1], 1'b0};
                st_data = {2{req_wdata_i[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = req_wdata_i;
            end
        endcase
    end

    always_comb begin
        ld_byte = ram_data_i[{lsb_q, 3'b000} +: 8];
        ld_half = ram_data_i[{lsb_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = ram_data_i;
        endcase
    end

    // Ready is registered so it stays low for the first cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            funct3_q      <= 3'b000;
            we_q          <= 1'b0;
            lsb_q         <= 2'b00;
            cnt_q         <= 2'b00;
            req_ready_o   <= 1'b0;
            resp_valid_o  <= 1'b0;
            resp_rdata_o  <= 32'h0;
            resp_err_o    <= 1'b0;
            ram_en_o      <= 1'b0;
            ram_address_o <= '0;
            ram_data_o    <= 32'h0;
            ram_wr_mask_o <= 4'b0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_ready_o && req_valid_i) begin
                        req_ready_o <= 1'b0;
                        funct3_q    <= req_funct3_i;
                        we_q        <= req_we_i;
                        lsb_q       <= req_addr_i[1:0];
                        if (req_err) begin
                            state_q      <= StResp;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'h0;
                        end else begin
                            state_q       <= StIssue;
                            ram_en_o      <= 1'b1;
                            ram_address_o <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            if (req_we_i) begin
                                ram_wr_mask_o <= st_mask;
                                ram_data_o    <= st_data;
                            end
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                StIssue: begin
                    ram_wr_mask_o <= 4'b0000;
                    ram_data_o    <= 32'h0;
                    if (we_q) begin
                        ram_en_o      <= 1'b0;
                        ram_address_o <= '0;
                        state_q       <= StResp;
                        resp_valid_o  <= 1'b1;
                        resp_rdata_o  <= 32'h0;
                        resp_err_o    <= 1'b0;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= 2'(RD_LATENCY - 1);
                    end
                end
                StWait: begin
                    if (cnt_q == 2'd0) begin
                        ram_en_o      <= 1'b0;
                        ram_address_o <= '0;
                        state_q       <= StResp;
                        resp_valid_o  <= 1'b1;
                        resp_rdata_o  <= ld_data;
                        resp_err_o    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    resp_valid_o <= 1'b0;
                    resp_rdata_o <= 32'h0;
                    resp_err_o   <= 1'b0;
                    req_ready_o  <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 1-cycle-latency RAM model behind one instance,
// and a bench-driven read port behind a RD_LATENCY=3 instance.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic [31:0] ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_wr_mask;
    logic [31:0] ram_rdata = 32'h0;

    logic        req_valid3 = 1'b0;
    logic        req_ready3;
    logic        resp_valid3;
    logic [31:0] resp_rdata3;
    logic        resp_err3;
    logic        ram_en3;
    logic [31:0] ram_address3;
    logic [31:0] ram_data3;
    logic [3:0]  ram_wr_mask3;
    logic [31:0] ram_rdata3 = 32'h0;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .RD_LATENCY(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .ram_en_o(ram_en), .ram_address_o(ram_address), .ram_data_o(ram_data),
        .ram_wr_mask_o(ram_wr_mask), .ram_data_i(ram_rdata)
    );

    mem_lsu #(.ADDR_W(32), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_funct3_i(3'b010),
        .req_we_i(1'b0), .req_addr_i(32'h0000_0010), .req_wdata_i(32'h0),
        .resp_valid_o(resp_valid3), .resp_rdata_o(resp_rdata3), .resp_err_o(resp_err3),
        .ram_en_o(ram_en3), .ram_address_o(ram_address3), .ram_data_o(ram_data3),
        .ram_wr_mask_o(ram_wr_mask3), .ram_data_i(ram_rdata3)
    );

    // Synchronous RAM, one cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_mask[b]) mem[ram_address[5:2]][8*b +: 8] <= ram_data[8*b +: 8];
            end
            ram_rdata <= mem[ram_address[5:2]];
        end
    end

    // Drives one request and watches until the response; lat counts cycles after acceptance.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int waited, output int lat,
                           output logic [31:0] rdata, output logic err, output int en_cycles,
                           output logic [3:0] mask_seen, output logic [31:0] data_seen,
                           output logic [31:0] addr_seen);
        waited = 0; lat = -1; rdata = 32'hx; err = 1'bx; en_cycles = 0;
        mask_seen = 4'b0; data_seen = 32'h0; addr_seen = 32'hffff_ffff;
        @(negedge clk);
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ram_en) begin
                en_cycles++;
                addr_seen = ram_address;
                if (ram_wr_mask != 4'b0) begin
                    mask_seen = ram_wr_mask;
                    data_seen = ram_data;
                end
            end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", req_ready); end
        total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_resp got=%b/%b/%h want=0/0/0", resp_valid, resp_err, resp_rdata); end
        total++; if (ram_en !== 1'b0 || ram_wr_mask !== 4'b0 || ram_data !== 32'h0 || ram_address !== 32'h0) begin
            bad++; $display("FAIL reset_ram got=%b/%b/%h/%h want=0", ram_en, ram_wr_mask, ram_data, ram_address); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_idle got=%b want=1", req_ready); end
    endtask

    task automatic test_word();
        int w, l, en; logic [31:0] rd, ds, as; logic e; logic [3:0] m;
        run_req(1'b1, 3'b010, 32'h0, 32'habcdef89, w, l, rd, e, en, m, ds, as);
        total++; if (l !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", l); end
        total++; if (e !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_resp got=%b/%h want=0/0", e, rd); end
        total++; if (en !== 1 || m !== 4'b1111 || ds !== 32'habcdef89 || as !== 32'h0) begin
            bad++; $display("FAIL sw_issue got en=%0d m=%b d=%h a=%h want 1/1111/abcdef89/0", en, m, ds, as); end
        run_req(1'b0, 3'b010, 32'h0, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (l !== 3 || rd !== 32'habcdef89 || e !== 1'b0) begin
            bad++; $display("FAIL lw_0 got lat=%0d d=%h e=%b want 3/abcdef89/0", l, rd, e); end
        total++; if (en !== 2 || m !== 4'b0) begin bad++; $display("FAIL lw_en got en=%0d m=%b want 2/0000", en, m); end
    endtask

    task automatic test_byte();
        int w, l, en; logic [31:0] rd, ds, as; logic e; logic [3:0] m;
        run_req(1'b1, 3'b010, 32'h4, 32'h12569034, w, l, rd, e, en, m, ds, as);
        run_req(1'b1, 3'b000, 32'h5, 32'h000000ff, w, l, rd, e, en, m, ds, as);
        total++; if (m !== 4'b0010 || ds !== 32'hffffffff || as !== 32'h4) begin
            bad++; $display("FAIL sb_lane got m=%b d=%h a=%h want 0010/ffffffff/4", m, ds, as); end
        run_req(1'b0, 3'b010, 32'h4, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'h1256ff34) begin bad++; $display("FAIL lw_4 got=%h want=1256ff34", rd); end
        run_req(1'b0, 3'b000, 32'h5, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'hffffffff) begin bad++; $display("FAIL lb_5 got=%h want=ffffffff", rd); end
        run_req(1'b0, 3'b100, 32'h5, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'h000000ff) begin bad++; $display("FAIL lbu_5 got=%h want=000000ff", rd); end
        run_req(1'b0, 3'b000, 32'h7, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'h00000012) begin bad++; $display("FAIL lb_7 got=%h want=00000012", rd); end
    endtask

    task automatic test_half();
        int w, l, en; logic [31:0] rd, ds, as; logic e; logic [3:0] m;
        run_req(1'b1, 3'b010, 32'h8, 32'h0, w, l, rd, e, en, m, ds, as);
        run_req(1'b1, 3'b001, 32'ha, 32'h00008001, w, l, rd, e, en, m, ds, as);
        total++; if (m !== 4'b1100 || ds !== 32'h80018001 || l !== 2) begin
            bad++; $display("FAIL sh_lane got m=%b d=%h lat=%0d want 1100/80018001/2", m, ds, l); end
        run_req(1'b0, 3'b001, 32'ha, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'hffff8001) begin bad++; $display("FAIL lh_a got=%h want=ffff8001", rd); end
        run_req(1'b0, 3'b101, 32'ha, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu_a got=%h want=00008001", rd); end
        run_req(1'b0, 3'b000, 32'hb, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'hffffff80) begin bad++; $display("FAIL lb_b got=%h want=ffffff80", rd); end
        run_req(1'b0, 3'b010, 32'h8, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'h80010000) begin bad++; $display("FAIL lw_8 got=%h want=80010000", rd); end
    endtask

    task automatic test_errors();
        logic        we_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_t [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ad_t [5] = '{32'h2, 32'h3, 32'h1, 32'h0, 32'h4};
        int w, l, en; logic [31:0] rd, ds, as; logic e; logic [3:0] m;
        for (int i = 0; i < 5; i++) begin
            run_req(we_t[i], f3_t[i], ad_t[i], 32'h5555aaaa, w, l, rd, e, en, m, ds, as);
            total++; if (l !== 1 || e !== 1'b1 || rd !== 32'h0 || en !== 0) begin
                bad++; $display("FAIL err_%0d got lat=%0d e=%b d=%h en=%0d want 1/1/0/0", i, l, e, rd, en); end
        end
        run_req(1'b0, 3'b010, 32'h4, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (rd !== 32'h1256ff34 || e !== 1'b0) begin
            bad++; $display("FAIL after_err got=%h/%b want=1256ff34/0", rd, e); end
    endtask

    task automatic test_back_to_back();
        int w, l, en; logic [31:0] rd, ds, as; logic e; logic [3:0] m;
        run_req(1'b0, 3'b010, 32'h0, 32'h0, w, l, rd, e, en, m, ds, as);
        run_req(1'b0, 3'b100, 32'h4, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (w !== 0 || rd !== 32'h00000034) begin
            bad++; $display("FAIL b2b got waited=%0d d=%h want 0/00000034", w, rd); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL resp_pulse got v=%b r=%b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid();
        int w, l, en, seen; logic [31:0] rd, ds, as; logic e; logic [3:0] m;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (ram_en !== 1'b1 || ram_wr_mask !== 4'b0) begin
            bad++; $display("FAIL mid_wait got en=%b m=%b want 1/0000", ram_en, ram_wr_mask); end
        reset_n = 1'b0;
        #1;
        total++; if (ram_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0 || ram_address !== 32'h0) begin
            bad++; $display("FAIL mid_clear got en=%b v=%b r=%b a=%h want 0", ram_en, resp_valid, req_ready, ram_address); end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        total++; if (seen !== 0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL mid_after got resp=%0d ready=%b want 0/1", seen, req_ready); end
        run_req(1'b0, 3'b010, 32'h0, 32'h0, w, l, rd, e, en, m, ds, as);
        total++; if (l !== 3 || rd !== 32'habcdef89 || e !== 1'b0) begin
            bad++; $display("FAIL mid_lw got lat=%0d d=%h e=%b want 3/abcdef89/0", l, rd, e); end
    endtask

    task automatic test_latency3();
        int en, lat, bad_addr;
        en = 0; lat = -1; bad_addr = 0;
        ram_rdata3 = 32'hdeadbeef;
        @(negedge clk);
        while (!req_ready3 && en < 10) begin @(negedge clk); en++; end
        en = 0;
        req_valid3 = 1'b1;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ram_en3) begin
                en++;
                if (ram_address3 !== 32'h10 || ram_wr_mask3 !== 4'b0) bad_addr++;
            end
            ram_rdata3 = (c == 4) ? 32'h5a5aa5a5 : 32'hdeadbeef;
            if (resp_valid3) begin
                lat = c;
                total++; if (resp_rdata3 !== 32'h5a5aa5a5 || resp_err3 !== 1'b0) begin
                    bad++; $display("FAIL rl3_data got=%h/%b want=5a5aa5a5/0", resp_rdata3, resp_err3); end
                break;
            end
        end
        total++; if (lat !== 5) begin bad++; $display("FAIL rl3_latency got=%0d want=5", lat); end
        total++; if (en !== 4 || bad_addr !== 0) begin
            bad++; $display("FAIL rl3_en got en=%0d badaddr=%0d want 4/0", en, bad_addr); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_latency3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Initiator side of the data-RAM port: the load/store unit that turns core memory requests into word-aligned RAM accesses.
- It generates byte write masks and shifted store data.
- It extracts and sign/zero-extends load data.
- It flags misaligned or illegal requests. It sits between the execute stage and mem_RAM.

Parameters:
- ADDR_W, 32, address width.
- RD_LATENCY, 1, RAM cycles from address/en valid to read data valid (1..4).

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- req_valid_i  input  1  core request valid
- req_ready_o  output  1  unit can accept a request
- req_funct3_i  input  3  RV32 width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  ADDR_W  byte address
- req_wdata_i  input  32  store data, right-aligned
- resp_valid_o  output  1  one-cycle completion pulse
- resp_rdata_o  output  32  extended load data; 0 for stores and errors
- resp_err_o  output  1  misaligned or illegal request, valid with resp_valid_o
- ram_en_o  output  1  RAM enable
- ram_address_o  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- ram_data_o  output  32  lane-shifted store data
- ram_wr_mask_o  output  4  byte write enables; 0000 = read
- ram_data_i  input  32  RAM read data

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE and counter clears.
  - All outputs are 0 except req_ready_o, which is 0 during reset and 1 in IDLE after release.
  - Reset mid-operation abandons the access with no response; a partially issued store may or may not have been written.
- FSM states IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready_o=1. On req_valid_i, latch funct3/we/addr/wdata and check legality.
    - Legal: go to ISSUE.
    - Illegal: go to RESP with err=1 and no RAM access.
  - ISSUE (1 cycle): ram_en_o=1, ram_address_o driven.
    - Store: mask and data driven, then go to RESP.
    - Load: mask=0000, then go to WAIT.
  - WAIT (RD_LATENCY cycles): ram_en_o=1, address held, mask=0000.
    - On the final WAIT cycle, capture ram_data_i and go to RESP.
  - RESP (1 cycle): resp_valid_o=1 with rdata/err, then go to IDLE. req_ready_o=0 in all states but IDLE.
- Illegal: funct3 is 011, 110 or 111, or the store uses funct3 100/101. Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00.
- Store lanes:
  - SB: mask=0001<<addr[1:0], data=wdata[7:0] replicated to all 4 lanes.
  - SH: mask=0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}.
  - SW: mask=1111, data=wdata.
- Load extraction from captured word w:
  - Byte = w[8*addr[1:0]+:8]; halfword = w[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW = w.
- Latency, with the request accepted at edge N:
  - Store: RAM write at end of cycle N+1, resp_valid_o in cycle N+2.
  - Load: resp_valid_o in cycle N+2+RD_LATENCY.
  - Error: resp_valid_o in cycle N+1.
- Output rules:
  - Outputs are registered.
  - Outside ISSUE/WAIT: ram_en_o=0, mask=0000, data=0.
  - No response backpressure; req_valid_i is ignored outside IDLE.
  - Back-to-back: a new request is accepted the cycle after RESP.

Test Plan:
- Reset, then SW addr 0x0 data 0xabcdef89 -> one ISSUE cycle with en=1, mask=1111, ram_data=0xabcdef89; resp_valid in cycle N+2, err=0; LW 0x0 returns 0xabcdef89 at N+3.
- SB addr 0x5 data 0x000000ff over word 0x12569034 at 0x4 -> mask=0010, ram_data=0xffffffff; LW 0x4 returns 0x1256ff34; LB 0x5 returns 0xffffffff; LBU 0x5 returns 0x000000ff.
- SH addr 0xa data 0x8001 -> mask=1100; LH 0xa returns 0xffff8001; LHU 0xa returns 0x00008001.
- LW 0x2, LH 0x3, SW 0x1, funct3=011 -> each gives resp_valid at N+1 with err=1, rdata=0, ram_en_o never asserted.
- Assert reset_n=0 during a load's WAIT state -> outputs clear immediately, no resp_valid; after release, req_ready_o=1 and the next LW completes normally.
- RD_LATENCY=3 build: LW -> en held 4 cycles at the same address; resp at N+5 carries data presented on ram_data_i in the last WAIT cycle.
